instr_fetch_mem: RTL

Clocked, parametrised instruction memory for the single-cycle/multi-cycle CPU fetch stage: byte-addressed storage, big-endian 32-bit word assembly, configurable wait-state latency and a valid/ready request–response handshake. It adds a byte-wide load port for program preload, out-of-range detection and optional alignment checking. It sits between the PC/fetch logic and the decode stage.

---
 rtl/instr_fetch_mem.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory for the CPU fetch stage: byte-addressed preload port, big-endian
// word fetch with WAIT_CYCLES latency and valid/ready handshake. Optional IM_ALIGN_CHECK_EN.
module instr_fetch_mem #(
  parameter int MEM_SIZE    = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        InstrReq,
  input  logic [31:0] InstrAddr,
  output logic        InstrReqReady,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        InstrRspReady,
  output logic        AddrFault,
  output logic        AlignFault,
  input  logic        LoadEn,
  input  logic [31:0] LoadAddr,
  input  logic [7:0]  LoadData
);

  localparam int          AW      = $clog2(MEM_SIZE);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [32:0] LAST_B  = 33'(MEM_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr;
  logic [7:0]  r_mem [MEM_SIZE];
  logic        r_valid;
  logic [31:0] r_instr;
  logic        r_afault;
  logic        r_alfault;

  logic        w_ready;
  logic        w_accept;
  logic        w_fill;
  logic [31:0] w_rd_addr;
  logic [32:0] w_end;
  logic        w_afault;
  logic        w_alfault;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic        w_load_ok;

  assign w_ready  = (r_state == S_IDLE) || ((r_state == S_RESP) && InstrRspReady);
  assign w_accept = InstrReq && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fill      = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_RESP;
          w_fill      = 1'b1;
        end
      end
      S_RESP: if (InstrRspReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A new request (from IDLE or back-to-back out of RESP) overrides the above
    if (w_accept) begin
      w_cnt_nxt = WAIT_LD;
      if (WAIT_LD != 4'd0) begin
        w_state_nxt = S_WAIT;
      end else begin
        w_state_nxt = S_RESP;
        w_fill      = 1'b1;
      end
    end
  end

  // Zero-wait fetches register the word on the accept edge, so read from the live address then
  assign w_rd_addr = (r_state == S_WAIT) ? r_addr : InstrAddr;
  assign w_end     = {1'b0, w_rd_addr} + 33'd3;
  assign w_afault  = (w_end > LAST_B);
  assign w_idx     = w_rd_addr[AW-1:0];

`ifdef IM_ALIGN_CHECK_EN
  assign w_alfault = (w_rd_addr[1:0] != 2'b00);
`else
  assign w_alfault = 1'b0;
`endif

  always_comb begin
    w_word = 32'h0000_0000;
    if (!w_afault && !w_alfault) begin
      w_word = {r_mem[w_idx], r_mem[w_idx + AW'(1)],
                r_mem[w_idx + AW'(2)], r_mem[w_idx + AW'(3)]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_valid   <= 1'b0;
      r_instr   <= 32'h0000_0000;
      r_afault  <= 1'b0;
      r_alfault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_fill) begin
        r_valid   <= 1'b1;
        r_instr   <= w_word;
        r_afault  <= w_afault;
        r_alfault <= w_alfault;
      end else if ((r_state == S_RESP) && InstrRspReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_addr <= InstrAddr;
  end

  // Storage is deliberately outside reset so preloaded code survives a CPU reset
  assign w_load_ok = LoadEn && (LoadAddr < 32'(MEM_SIZE));

  always_ff @(posedge clk) begin
    if (w_load_ok) r_mem[LoadAddr[AW-1:0]] <= LoadData;
  end

  assign InstrReqReady = w_ready;
  assign Instr         = r_instr;
  assign InstrValid    = r_valid;
  assign AddrFault     = r_afault;
  assign AlignFault    = r_alfault;

endmodule
